dyn_console_scroll: RTL and testbench

Parametrised text-console cell-address generator for the RGB pixel stream. It sits between the timing generator and the glyph/VRAM read path. For every pixel it computes the VRAM address of the character cell under the beam, accounting for a hardware-scrolled top row. It also emits the cell's screen origin and a blinking-cursor hit flag, and delays the stream so all outputs stay aligned.

---
 rtl/console_pkg.sv | 28 ++
 rtl/console_scroll_ctl.sv | 69 ++++++
 rtl/dyn_console_scroll.sv | 115 +++++++++++
 tb/tb_dyn_console_scroll.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants and helpers for the text-console cell-address pipeline.
package console_pkg;

  localparam int STREAM_W = 26;
  localparam int ACTIVE   = 0;
  localparam int VS       = 1;
  localparam int HS       = 2;
  localparam int YC_LSB   = 3;
  localparam int YC_MSB   = 12;
  localparam int XC_LSB   = 13;
  localparam int XC_MSB   = 22;
  localparam int RGB_LSB  = 23;
  localparam int RGB_MSB  = 25;

  // Modulo add for two row indices that are both already below rows.
  function automatic logic [9:0] row_wrap_add(input logic [9:0] a, input logic [9:0] b,
                                              input int rows);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 11'(rows)) begin
      sum = sum - 11'(rows);
    end else begin
      sum = sum;
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/console_scroll_ctl.sv
// Scroll request handshake, top-row pointer and frame blink counter.
module console_scroll_ctl
  import console_pkg::*;
#(
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_start_i,
  input  logic                  scroll_req_i,
  output logic [9:0]            top_row_o,
  output logic [BLINK_LOG2-1:0] blink_o,
  output logic                  scroll_ack_o
);

  logic                  pending_q, pending_d;
  logic                  consumed_q, consumed_d;
  logic [9:0]            top_row_q, top_row_d;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
  logic                  ack_q, ack_d;
  logic                  want_s;
  logic                  fire_s;

  // A request level that was already served by an ack stays blocked until it drops.
  always_comb begin
    want_s     = pending_q || (scroll_req_i && !consumed_q);
    fire_s     = frame_start_i && want_s;
    pending_d  = want_s && !fire_s;
    ack_d      = fire_s;
    top_row_d  = top_row_q;
    consumed_d = consumed_q;
    blink_d    = blink_q;
    if (fire_s) begin
      top_row_d  = row_wrap_add(top_row_q, 10'd1, ROWS);
      consumed_d = scroll_req_i;
    end else if (!scroll_req_i) begin
      consumed_d = 1'b0;
    end else begin
      consumed_d = consumed_q;
    end
    if (frame_start_i) begin
      blink_d = blink_q + BLINK_LOG2'(1);
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      consumed_q <= 1'b0;
      top_row_q  <= 10'd0;
      blink_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      consumed_q <= consumed_d;
      top_row_q  <= top_row_d;
      blink_q    <= blink_d;
      ack_q      <= ack_d;
    end
  end

  assign top_row_o    = top_row_q;
  assign blink_o      = blink_q;
  assign scroll_ack_o = ack_q;

endmodule

// File: rtl/dyn_console_scroll.sv
// Two-stage pipeline mapping each pixel to its character cell VRAM address,
// cell origin and cursor hit, with a hardware-scrolled top row.
module dyn_console_scroll
  import console_pkg::*;
#(
  parameter int GLYPH_LOG2 = 4,
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int ADDR_W     = 11,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                px_clk,
  input  logic                reset_n,
  input  logic [STREAM_W-1:0] RGBStr_i,
  input  logic                scroll_req,
  input  logic                cursor_en,
  input  logic [9:0]          cursor_x,
  input  logic [9:0]          cursor_y,
  output logic [STREAM_W-1:0] RGBStr_o,
  output logic [ADDR_W-1:0]   addr_vram,
  output logic [9:0]          pos_x,
  output logic [9:0]          pos_y,
  output logic                in_text,
  output logic                cursor_hit,
  output logic                scroll_ack,
  output logic [9:0]          top_row
);

  logic [9:0]            xc_s, yc_s, col_s, row_s, eff_row_s;
  logic                  inside_s, cur_s, frame_start_s;
  logic [BLINK_LOG2-1:0] blink_s;

  logic [9:0]            col_q, row_q, eff_row_q;
  logic                  inside_q, cur_q;
  logic [STREAM_W-1:0]   str1_q;

  logic [19:0]           lin_s;
  logic [ADDR_W-1:0]     addr_d, addr_q;
  logic [9:0]            pos_x_q, pos_y_q;
  logic                  in_text_q, hit_d, hit_q;
  logic [STREAM_W-1:0]   str2_q;

  console_scroll_ctl #(
    .ROWS       (ROWS),
    .BLINK_LOG2 (BLINK_LOG2)
  ) u_ctl (
    .clk_i         (px_clk),
    .rst_ni        (reset_n),
    .frame_start_i (frame_start_s),
    .scroll_req_i  (scroll_req),
    .top_row_o     (top_row),
    .blink_o       (blink_s),
    .scroll_ack_o  (scroll_ack)
  );

  // eff_row is only meaningful for rows on screen; off-screen addresses are forced to 0 later.
  always_comb begin
    xc_s          = RGBStr_i[XC_MSB:XC_LSB];
    yc_s          = RGBStr_i[YC_MSB:YC_LSB];
    col_s         = xc_s >> GLYPH_LOG2;
    row_s         = yc_s >> GLYPH_LOG2;
    frame_start_s = (xc_s == 10'd0) && (yc_s == 10'd0);
    inside_s      = (col_s < 10'(COLS)) && (row_s < 10'(ROWS));
    eff_row_s     = row_wrap_add(row_s, top_row, ROWS);
    cur_s         = cursor_en && (col_s == cursor_x) && (row_s == cursor_y);
  end

  always_comb begin
    lin_s = 20'(eff_row_q) * 20'(COLS) + 20'(col_q);
    if (inside_q) begin
      addr_d = lin_s[ADDR_W-1:0];
    end else begin
      addr_d = '0;
    end
    hit_d = cur_q && inside_q && blink_s[BLINK_LOG2-1];
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q     <= 10'd0;
      row_q     <= 10'd0;
      eff_row_q <= 10'd0;
      inside_q  <= 1'b0;
      cur_q     <= 1'b0;
      str1_q    <= '0;
      addr_q    <= '0;
      pos_x_q   <= 10'd0;
      pos_y_q   <= 10'd0;
      in_text_q <= 1'b0;
      hit_q     <= 1'b0;
      str2_q    <= '0;
    end else begin
      col_q     <= col_s;
      row_q     <= row_s;
      eff_row_q <= eff_row_s;
      inside_q  <= inside_s;
      cur_q     <= cur_s;
      str1_q    <= RGBStr_i;
      addr_q    <= addr_d;
      pos_x_q   <= col_q << GLYPH_LOG2;
      pos_y_q   <= row_q << GLYPH_LOG2;
      in_text_q <= inside_q;
      hit_q     <= hit_d;
      str2_q    <= str1_q;
    end
  end

  assign RGBStr_o   = str2_q;
  assign addr_vram  = addr_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign in_text    = in_text_q;
  assign cursor_hit = hit_q;

endmodule

// File: tb/tb_dyn_console_scroll.sv
// Self-checking bench for dyn_console_scroll: vector table, corner sequences
// and randomized traffic against a behavioural model.
module tb_dyn_console_scroll;

  logic        px_clk = 1'b0;
  logic        reset_n;
  logic [25:0] RGBStr_i;
  logic        scroll_req;
  logic        cursor_en;
  logic [9:0]  cursor_x, cursor_y;
  logic [25:0] RGBStr_o;
  logic [10:0] addr_vram;
  logic [9:0]  pos_x, pos_y, top_row;
  logic        in_text, cursor_hit, scroll_ack;

  always #5 px_clk = ~px_clk;

  dyn_console_scroll dut (
    .px_clk     (px_clk),
    .reset_n    (reset_n),
    .RGBStr_i   (RGBStr_i),
    .scroll_req (scroll_req),
    .cursor_en  (cursor_en),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .RGBStr_o   (RGBStr_o),
    .addr_vram  (addr_vram),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .in_text    (in_text),
    .cursor_hit (cursor_hit),
    .scroll_ack (scroll_ack),
    .top_row    (top_row)
  );

  typedef struct {
    logic [25:0] str;
    int          addr;
    int          px;
    int          py;
    bit          intext;
    bit          hit;
  } exp_t;

  typedef struct {
    int xc; int yc; bit cen; int cx; int cy;
    int addr; int px; int py; bit intext; bit hit;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t s1, s2;
  bit   exp_ack;
  int   m_top, m_frames;
  bit   m_pend, m_served;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("stream", int'(RGBStr_o), int'(s2.str));
    chk("addr", int'(addr_vram), s2.addr);
    chk("pos_x", int'(pos_x), s2.px);
    chk("pos_y", int'(pos_y), s2.py);
    chk("in_text", int'(in_text), int'(s2.intext));
    chk("cursor_hit", int'(cursor_hit), int'(s2.hit));
    chk("scroll_ack", int'(scroll_ack), int'(exp_ack));
    chk("top_row", int'(top_row), m_top);
  endtask

  task automatic model_clear();
    s1 = '{default: 0};
    s2 = '{default: 0};
    exp_ack  = 1'b0;
    m_top    = 0;
    m_frames = 0;
    m_pend   = 1'b0;
    m_served = 1'b0;
  endtask

  task automatic set_px(input int xc, input int yc);
    logic [2:0] rgb;
    logic [2:0] fl;
    rgb = 3'($urandom);
    fl  = 3'($urandom);
    RGBStr_i = {rgb, 10'(xc), 10'(yc), fl};
  endtask

  // One clock: model consumes the current inputs, then the DUT outputs are compared.
  task automatic tick();
    exp_t n;
    int   xc, yc, col, row;
    bit   bnd, want, fire;
    xc  = int'(RGBStr_i[22:13]);
    yc  = int'(RGBStr_i[12:3]);
    col = xc / 16;
    row = yc / 16;
    bnd = (xc == 0) && (yc == 0);
    if (bnd) m_frames++;
    n.str    = RGBStr_i;
    n.intext = (col < 40) && (row < 30);
    n.addr   = n.intext ? ((row + m_top) % 30) * 40 + col : 0;
    n.px     = (col * 16) % 1024;
    n.py     = (row * 16) % 1024;
    n.hit    = n.intext && cursor_en && (col == int'(cursor_x)) && (row == int'(cursor_y))
               && ((m_frames % 32) >= 16);
    want = m_pend || (scroll_req && !m_served);
    fire = bnd && want;
    m_pend = want && !fire;
    if (fire) begin
      m_top    = (m_top + 1) % 30;
      m_served = scroll_req;
    end else if (!scroll_req) begin
      m_served = 1'b0;
    end
    exp_ack = fire;
    s2 = s1;
    s1 = n;
    @(posedge px_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all();
    @(negedge px_clk);
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    set_px(700, 500);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic scroll_frame();
    scroll_req = 1'b1;
    set_px(0, 0);
    tick();
    chk("scroll_ack_frame", int'(scroll_ack), 1);
    scroll_req = 1'b0;
    idle(2);
  endtask

  vec_t tbl[8];
  int   acks;
  int   bc;

  initial begin
    reset_n    = 1'b0;
    scroll_req = 1'b0;
    cursor_en  = 1'b0;
    cursor_x   = 10'd0;
    cursor_y   = 10'd0;
    RGBStr_i   = '0;
    model_clear();
    #3;
    check_all();
    chk("reset_top_row", int'(top_row), 0);
    chk("reset_addr", int'(addr_vram), 0);
    @(negedge px_clk);
    reset_n = 1'b1;

    tbl[0] = '{0,    0,    0, 0, 0, 0,    0,    0,    1, 0};
    tbl[1] = '{624,  464,  0, 0, 0, 1199, 624,  464,  1, 0};
    tbl[2] = '{640,  0,    0, 0, 0, 0,    640,  0,    0, 0};
    tbl[3] = '{17,   35,   0, 0, 0, 81,   16,   32,   1, 0};
    tbl[4] = '{100,  479,  0, 0, 0, 1166, 96,   464,  1, 0};
    tbl[5] = '{0,    480,  0, 0, 0, 0,    0,    480,  0, 0};
    tbl[6] = '{1023, 1023, 0, 0, 0, 0,    1008, 1008, 0, 0};
    tbl[7] = '{48,   32,   1, 3, 2, 83,   48,   32,   1, 0};
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        cursor_en = tbl[i].cen;
        cursor_x  = 10'(tbl[i].cx);
        cursor_y  = 10'(tbl[i].cy);
        set_px(tbl[i].xc, tbl[i].yc);
      end else begin
        set_px(700, 500);
      end
      tick();
      if (i >= 1) begin
        chk("tbl_addr", int'(addr_vram), tbl[i-1].addr);
        chk("tbl_pos_x", int'(pos_x), tbl[i-1].px);
        chk("tbl_pos_y", int'(pos_y), tbl[i-1].py);
        chk("tbl_in_text", int'(in_text), int'(tbl[i-1].intext));
        chk("tbl_cursor_hit", int'(cursor_hit), int'(tbl[i-1].hit));
      end
    end
    cursor_en = 1'b0;

    // 29 scrolls wind top_row to 29; cell (1,1) then maps to VRAM row 0.
    for (int f = 0; f < 29; f++) scroll_frame();
    chk("top_row_29", int'(top_row), 29);
    set_px(16, 16);
    tick();
    tick();
    chk("scrolled_addr", int'(addr_vram), 1);

    // Request held across two boundaries is served only once; top_row wraps 29->0.
    acks = 0;
    scroll_req = 1'b1;
    for (int b = 0; b < 2; b++) begin
      set_px(0, 0);
      tick();
      acks += int'(scroll_ack);
      set_px(700, 500);
      for (int k = 0; k < 3; k++) begin
        tick();
        acks += int'(scroll_ack);
      end
    end
    chk("held_req_acks", acks, 1);
    chk("top_row_wrap", int'(top_row), 0);
    scroll_req = 1'b0;
    idle(1);

    acks = 0;
    scroll_req = 1'b1;
    set_px(0, 0);
    tick();
    acks += int'(scroll_ack);
    scroll_req = 1'b0;
    set_px(700, 500);
    for (int k = 0; k < 3; k++) begin tick(); acks += int'(scroll_ack); end
    set_px(0, 0);
    tick();
    acks += int'(scroll_ack);
    idle(1);
    chk("dropped_req_acks", acks, 1);
    chk("top_row_one", int'(top_row), 1);

    // Pending request is lost across a mid-frame reset.
    scroll_req = 1'b1;
    idle(1);
    scroll_req = 1'b0;
    idle(1);
    do_reset();
    set_px(0, 0);
    tick();
    chk("reset_drops_pending", int'(scroll_ack), 0);
    chk("reset_top_row2", int'(top_row), 0);
    idle(1);

    // Blink phase over many frames with top_row=5; cursor cell stays at logical (3,2).
    for (int f = 0; f < 5; f++) scroll_frame();
    bc = 6;
    cursor_en = 1'b1;
    cursor_x  = 10'd3;
    cursor_y  = 10'd2;
    for (int f = 0; f < 40; f++) begin
      set_px(0, 0);
      tick();
      bc++;
      set_px(48, 32);
      tick();
      tick();
      chk("blink_hit", int'(cursor_hit), int'((bc % 32) >= 16));
      if (f == 0) chk("cursor_addr_top5", int'(addr_vram), 283);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) set_px(0, 0);
      else set_px(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
      if (scroll_req && (scroll_ack || $urandom_range(0, 39) == 0)) scroll_req = 1'b0;
      else if (!scroll_req && $urandom_range(0, 19) == 0) scroll_req = 1'b1;
      if ($urandom_range(0, 99) == 0) begin
        cursor_en = 1'($urandom);
        cursor_x  = 10'($urandom_range(0, 41));
        cursor_y  = 10'($urandom_range(0, 31));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
